// File: rtl/bitstream_packer.sv
// Packs MSB-first variable-length codewords into 32-bit words and queues them in a word FIFO.
// Define BITSTREAM_PACKER_BSWAP_EN to present each word little-endian (first stream byte in [7:0]).
module bitstream_packer #(
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_CODE_BITS = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sb_enable,
  input  logic [63:0] sb_val,
  input  logic [63:0] sb_size_of_bit,
  input  logic        sb_flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_nbytes,
  output logic        out_last,
  output logic [31:0] total_bytes,
  output logic        overflow,
  output logic        flush_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [6:0]  MAX_N   = 7'(MAX_CODE_BITS);
  localparam logic [PW:0] DEPTH_W = (PW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  nbytes;
    logic        last;
  } entry_t;

  logic [31:0]   acc_q, acc_d;
  logic [4:0]    pend_q, pend_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        mem_d [FIFO_DEPTH];
  logic [31:0]   total_bytes_q, total_bytes_d;
  logic          overflow_q, overflow_d;
  logic          flush_done_q, flush_done_d;

  logic [6:0]    n;
  logic [6:0]    total_bits;
  logic [6:0]    shamt;
  logic [1:0]    nfull;
  logic [1:0]    push_cnt;
  logic [1:0]    accept_cnt;
  logic [63:0]   code;
  logic [95:0]   merged;
  logic [31:0]   acc_new;
  logic [4:0]    pend_new;
  logic [2:0]    flush_nbytes;
  entry_t        push_e [4];
  logic [PW-1:0] count;
  logic [PW:0]   free_slots;
  logic [PW:0]   push_ext;
  logic          pop;
  entry_t        head;
  logic          size_unused;

  assign size_unused = ^sb_size_of_bit[63:7];

  // Pending bits sit left-justified at the top of a 96-bit window; the new code lands right after them.
  always_comb begin
    n = (sb_size_of_bit[6:0] > MAX_N) ? MAX_N : sb_size_of_bit[6:0];
    if (!sb_enable) begin
      n = 7'd0;
    end
    code       = (n >= 7'd64) ? sb_val : (sb_val & ((64'd1 << n) - 64'd1));
    total_bits = {2'b00, pend_q} + n;
    shamt      = 7'd96 - {2'b00, pend_q} - n;
    merged     = {acc_q, 64'd0} | ({32'd0, code} << shamt);
    nfull      = total_bits[6:5];
    pend_new   = total_bits[4:0];
    case (nfull)
      2'd0:    acc_new = merged[95:64];
      2'd1:    acc_new = merged[63:32];
      default: acc_new = merged[31:0];
    endcase
    flush_nbytes = {1'b0, pend_new[4:3]} + {2'b00, (pend_new[2:0] != 3'd0)};

    push_e[0] = '{data: merged[95:64], nbytes: 3'd4, last: 1'b0};
    push_e[1] = '{data: merged[63:32], nbytes: 3'd4, last: 1'b0};
    push_e[2] = '0;
    push_e[3] = '0;
    push_cnt  = nfull;
    acc_d     = acc_new;
    pend_d    = pend_new;

    // Bits past the pending count are always zero, so the flushed word is already padded.
    if (sb_flush) begin
      if (pend_new != 5'd0) begin
        push_e[nfull] = '{data: acc_new, nbytes: flush_nbytes, last: 1'b1};
        push_cnt      = nfull + 2'd1;
        acc_d         = '0;
        pend_d        = '0;
      end else if (nfull != 2'd0) begin
        push_e[nfull - 2'd1].last = 1'b1;
      end
    end
  end

  // A same-cycle pop frees its slot before pushes are admitted; excess pushes are dropped in order.
  always_comb begin
    count      = wr_ptr_q - rd_ptr_q;
    pop        = (count != '0) && out_ready;
    free_slots = DEPTH_W - {1'b0, count} + {{PW{1'b0}}, pop};
    push_ext   = {{(PW - 1){1'b0}}, push_cnt};
    accept_cnt = (push_ext > free_slots) ? free_slots[1:0] : push_cnt;
    overflow_d = overflow_q | (push_ext > free_slots);

    mem_d         = mem_q;
    total_bytes_d = total_bytes_q;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < accept_cnt) begin
        mem_d[wr_ptr_q[AW-1:0] + AW'(i)] = push_e[i];
        total_bytes_d = total_bytes_d + {29'd0, push_e[i].nbytes};
      end
    end
    wr_ptr_d     = wr_ptr_q + {{(PW - 2){1'b0}}, accept_cnt};
    rd_ptr_d     = rd_ptr_q + {{(PW - 1){1'b0}}, pop};
    flush_done_d = sb_flush;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_q         <= '0;
      pend_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      total_bytes_q <= '0;
      overflow_q    <= 1'b0;
      flush_done_q  <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      pend_q        <= pend_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      total_bytes_q <= total_bytes_d;
      overflow_q    <= overflow_d;
      flush_done_q  <= flush_done_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid = (wr_ptr_q != rd_ptr_q);

  // Stale storage never reaches the port: the word fields read as zero while the FIFO is empty.
  always_comb begin
    out_data   = '0;
    out_nbytes = '0;
    out_last   = 1'b0;
    if (out_valid) begin
`ifdef BITSTREAM_PACKER_BSWAP_EN
      out_data = {head.data[7:0], head.data[15:8], head.data[23:16], head.data[31:24]};
`else
      out_data = head.data;
`endif
      out_nbytes = head.nbytes;
      out_last   = head.last;
    end
  end

  assign total_bytes = total_bytes_q;
  assign overflow    = overflow_q;
  assign flush_done  = flush_done_q;

endmodule

// File: tb/tb_bitstream_packer.sv
// Bench for bitstream_packer: directed literal cases plus random traffic, checked every cycle
// against a bit-queue model of the packer and word FIFO.
module tb_bitstream_packer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  nbytes;
    logic        last;
  } word_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        sb_enable;
  logic [63:0] sb_val;
  logic [63:0] sb_size_of_bit;
  logic        sb_flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_nbytes;
  logic        out_last;
  logic [31:0] total_bytes;
  logic        overflow;
  logic        flush_done;

  int vectors     = 0;
  int miscompares = 0;

  bit          pend[$];
  word_t       fifo_m[$];
  logic [31:0] m_bytes = '0;
  logic        m_ovf   = 1'b0;
  logic        m_fd    = 1'b0;
  bit          model_live = 1'b0;

  bitstream_packer #(
    .FIFO_DEPTH   (DEPTH),
    .MAX_CODE_BITS(64)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .sb_enable     (sb_enable),
    .sb_val        (sb_val),
    .sb_size_of_bit(sb_size_of_bit),
    .sb_flush      (sb_flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_nbytes    (out_nbytes),
    .out_last      (out_last),
    .total_bytes   (total_bytes),
    .overflow      (overflow),
    .flush_done    (flush_done)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] layout(input logic [31:0] d);
`ifdef BITSTREAM_PACKER_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic en, input logic [63:0] val,
                               input logic [63:0] size, input logic flush, input logic ready);
    @(posedge clock);
    #1;
    reset_n        = rst_n;
    sb_enable      = en;
    sb_val         = val;
    sb_size_of_bit = size;
    sb_flush       = flush;
    out_ready      = ready;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clock);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", out_data, 32'd0);
    checkOutput("rst_nbytes", 32'(out_nbytes), 32'd0);
    checkOutput("rst_total", total_bytes, 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
  endtask

  task automatic expectWord(input string name, input logic [31:0] data, input logic [2:0] nb, input logic last);
    checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, "_data"}, out_data, layout(data));
    checkOutput({name, "_nbytes"}, 32'(out_nbytes), 32'(nb));
    checkOutput({name, "_last"}, 32'(out_last), 32'(last));
  endtask

  // Reference: stream bits kept in a queue, cut into words 32 at a time, FIFO as a bounded queue.
  always @(posedge clock) begin : model
    word_t       fresh[$];
    word_t       tmp;
    logic [31:0] w;
    int          n;
    int          nb;
    if (!reset_n) begin
      pend.delete();
      fifo_m.delete();
      m_bytes    = '0;
      m_ovf      = 1'b0;
      m_fd       = 1'b0;
      model_live = 1'b1;
    end else begin
      fresh.delete();
      if (fifo_m.size() > 0 && out_ready) fifo_m.delete(0);
      if (sb_enable) begin
        n = int'(sb_size_of_bit[6:0]);
        if (n > 64) n = 64;
        for (int b = n - 1; b >= 0; b--) pend.push_back(sb_val[b]);
      end
      while (pend.size() >= 32) begin
        w = '0;
        for (int b = 31; b >= 0; b--) w[b] = pend.pop_front();
        fresh.push_back('{w, 3'd4, 1'b0});
      end
      if (sb_flush) begin
        if (pend.size() > 0) begin
          w  = '0;
          nb = (pend.size() + 7) / 8;
          for (int b = 31; pend.size() > 0; b--) w[b] = pend.pop_front();
          fresh.push_back('{w, 3'(nb), 1'b1});
        end else if (fresh.size() > 0) begin
          tmp = fresh[fresh.size() - 1];
          tmp.last = 1'b1;
          fresh[fresh.size() - 1] = tmp;
        end
      end
      foreach (fresh[i]) begin
        if (fifo_m.size() < DEPTH) begin
          fifo_m.push_back(fresh[i]);
          m_bytes = m_bytes + 32'(fresh[i].nbytes);
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_fd = sb_flush;
    end
  end

  always @(negedge clock) begin : compare
    if (model_live) begin
      checkOutput("out_valid", 32'(out_valid), 32'(fifo_m.size() > 0));
      if (fifo_m.size() > 0) begin
        checkOutput("out_data", out_data, layout(fifo_m[0].data));
        checkOutput("out_nbytes", 32'(out_nbytes), 32'(fifo_m[0].nbytes));
        checkOutput("out_last", 32'(out_last), 32'(fifo_m[0].last));
      end
      checkOutput("total_bytes", total_bytes, m_bytes);
      checkOutput("overflow", 32'(overflow), 32'(m_ovf));
      checkOutput("flush_done", 32'(flush_done), 32'(m_fd));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [63:0] val;
    logic [63:0] size;
    int          ready_pct;
    reset_n        = 1'b0;
    sb_enable      = 1'b0;
    sb_val         = '0;
    sb_size_of_bit = '0;
    sb_flush       = 1'b0;
    out_ready      = 1'b1;

    // Two codes completing exactly one word.
    doReset();
    applyStimulus(1'b1, 1'b1, 64'h5, 64'd3, 1'b0, 1'b1);
    @(negedge clock);
    applyStimulus(1'b1, 1'b1, 64'h1FFF_FFFF, 64'd29, 1'b0, 1'b1);
    @(negedge clock);
    checkOutput("t1_early_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clock);
    expectWord("t1", 32'hBFFF_FFFF, 3'd4, 1'b0);
    checkOutput("t1_total", total_bytes, 32'd4);

    // Short code closed by a later flush.
    doReset();
    applyStimulus(1'b1, 1'b1, 64'h3, 64'd2, 1'b0, 1'b1);
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1);
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clock);
    expectWord("t2", 32'hC000_0000, 3'd1, 1'b1);
    checkOutput("t2_flush_done", 32'(flush_done), 32'd1);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clock);
    checkOutput("t2_flush_done_drop", 32'(flush_done), 32'd0);

    // Two full words in one cycle, then a 2-byte tail.
    doReset();
    applyStimulus(1'b1, 1'b1, 64'hABCD, 64'd16, 1'b0, 1'b1);
    @(negedge clock);
    applyStimulus(1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 64'd64, 1'b0, 1'b1);
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1);
    @(negedge clock);
    expectWord("t3a", 32'hABCD_0123, 3'd4, 1'b0);
    checkOutput("t3_total_mid", total_bytes, 32'd8);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clock);
    expectWord("t3b", 32'h4567_89AB, 3'd4, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clock);
    expectWord("t3c", 32'hCDEF_0000, 3'd2, 1'b1);
    checkOutput("t3_total", total_bytes, 32'd10);

    // Flush with nothing pending marks the word completed in the same cycle.
    doReset();
    applyStimulus(1'b1, 1'b1, 64'h1234_5678, 64'd32, 1'b1, 1'b1);
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clock);
    expectWord("t3d", 32'h1234_5678, 3'd4, 1'b1);

    // Single bit with same-cycle flush, then an empty flush.
    doReset();
    applyStimulus(1'b1, 1'b1, 64'h1, 64'd1, 1'b1, 1'b1);
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clock);
    expectWord("t4", 32'h8000_0000, 3'd1, 1'b1);
    checkOutput("t4_flush_done", 32'(flush_done), 32'd1);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1);
    @(negedge clock);
    checkOutput("t4_empty_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clock);
    checkOutput("t4_empty_flush_valid", 32'(out_valid), 32'd0);
    checkOutput("t4_empty_flush_done", 32'(flush_done), 32'd1);

    // Overflow with the consumer stalled, then drain in order.
    doReset();
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b1, 64'(k), 64'd32, 1'b0, 1'b0);
      @(negedge clock);
    end
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("t5_overflow", 32'(overflow), 32'd1);
    checkOutput("t5_total", total_bytes, 32'd16);
    expectWord("t5_head", 32'd1, 3'd4, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clock);
    expectWord("t5_stall", 32'd1, 3'd4, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clock);
    expectWord("t5_drain1", 32'd1, 3'd4, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
      @(negedge clock);
      expectWord("t5_drain", 32'(k), 3'd4, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clock);
    checkOutput("t5_empty", 32'(out_valid), 32'd0);

    // Reset with queued words and pending bits discards everything.
    doReset();
    applyStimulus(1'b1, 1'b1, 64'h1, 64'd32, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 64'h2, 64'd32, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 64'h7F, 64'd7, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("t6_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_overflow", 32'(overflow), 32'd0);
    checkOutput("t6_total", total_bytes, 32'd0);
    applyStimulus(1'b1, 1'b1, 64'hDEAD_BEEF, 64'd32, 1'b0, 1'b1);
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clock);
    checkOutput("t6_valid_after", 32'(out_valid), 32'd1);
`ifdef BITSTREAM_PACKER_BSWAP_EN
    checkOutput("t6_data", out_data, 32'hEFBE_ADDE);
`else
    checkOutput("t6_data", out_data, 32'hDEAD_BEEF);
`endif

    // Random traffic alternating between a slow and a fast consumer.
    for (int c = 0; c < 2500; c++) begin
      ready_pct = (((c / 500) % 2) == 1) ? 90 : 40;
      val  = {$urandom, $urandom};
      size = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) size[6:0] = 7'($urandom_range(0, 127));
      else                           size[6:0] = 7'($urandom_range(0, 9));
      applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), val, size,
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < ready_pct));
    end
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, (c == 0), 1'b1);
    end
    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
